ysyx_23060025_axi_arbiter: RTL and testbench

- Two-master, one-slave AXI arbiter: IFU (read-only, master 0) and LSU (read/write, master 1) share the single controller-side AXI port of the xbar.
- Holds a grant for a whole transaction and forwards only the granted master's handshakes.
- Decodes the latched request address into the xbar device select (`axi_device`), so the select is stable for the whole transaction.

---
 rtl/ysyx_23060025_axi_arbiter_pkg.sv | 28 ++
 rtl/ysyx_23060025_axi_arbiter_if.sv | 88 ++++++++
 rtl/ysyx_23060025_addr_decode.sv | 19 +
 rtl/ysyx_23060025_axi_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_23060025_axi_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060025_axi_arbiter_pkg.sv
// Shared constants for the IFU/LSU AXI arbiter and the xbar address decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro used by the arbiter: ARB_ROUND_ROBIN_EN.
package ysyx_23060025_axi_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_RD_AR = 3'd1,
    ARB_RD_R  = 3'd2,
    ARB_WR_AW = 3'd3,
    ARB_WR_B  = 3'd4
  } arb_state_t;

  // Downstream AXI ids identify the originating master
  localparam logic [3:0] ARB_ID_IFU = 4'd0;
  localparam logic [3:0] ARB_ID_LSU = 4'd1;

  // Every transfer is a single 32-bit INCR beat
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // CLINT window, shared with the xbar
  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0001_0000;

endpackage

// File: rtl/ysyx_23060025_axi_arbiter_if.sv
// Bundle of the two upstream master ports (IFU = m0, LSU = m1) and the downstream xbar port.
// Latency: n/a (wires only).
// Backpressure: plain AXI valid/ready; 'master' is the arbiter view, 'slave' the surrounding masters and xbar.
interface ysyx_23060025_axi_arbiter_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  // IFU read channel
  logic [ADDR_LEN-1:0] m0_ar_addr;
  logic                m0_ar_valid, m0_ar_ready;
  logic [DATA_LEN-1:0] m0_r_data;
  logic [1:0]          m0_r_resp;
  logic                m0_r_valid, m0_r_ready, m0_r_last;
  // LSU read/write channels
  logic [ADDR_LEN-1:0] m1_ar_addr;
  logic                m1_ar_valid, m1_ar_ready;
  logic [DATA_LEN-1:0] m1_r_data;
  logic [1:0]          m1_r_resp;
  logic                m1_r_valid, m1_r_ready, m1_r_last;
  logic [ADDR_LEN-1:0] m1_aw_addr;
  logic                m1_aw_valid, m1_aw_ready;
  logic [DATA_LEN-1:0] m1_w_data;
  logic [3:0]          m1_w_strb;
  logic                m1_w_valid, m1_w_ready, m1_w_last;
  logic [1:0]          m1_b_resp;
  logic                m1_b_valid, m1_b_ready;
  // Downstream xbar port
  logic [ADDR_LEN-1:0] s_ar_addr;
  logic                s_ar_valid, s_ar_ready;
  logic [3:0]          s_ar_id;
  logic [7:0]          s_ar_len;
  logic [2:0]          s_ar_size;
  logic [1:0]          s_ar_burst;
  logic [DATA_LEN-1:0] s_r_data;
  logic [1:0]          s_r_resp;
  logic                s_r_valid, s_r_ready, s_r_last;
  logic [3:0]          s_r_id;
  logic [ADDR_LEN-1:0] s_aw_addr;
  logic                s_aw_valid, s_aw_ready;
  logic [3:0]          s_aw_id;
  logic [7:0]          s_aw_len;
  logic [2:0]          s_aw_size;
  logic [1:0]          s_aw_burst;
  logic [DATA_LEN-1:0] s_w_data;
  logic [3:0]          s_w_strb;
  logic                s_w_valid, s_w_ready, s_w_last;
  logic [1:0]          s_b_resp;
  logic                s_b_valid, s_b_ready;
  logic [3:0]          s_b_id;

  modport master (
    input  m0_ar_addr, m0_ar_valid, m0_r_ready,
    output m0_ar_ready, m0_r_data, m0_r_resp, m0_r_valid, m0_r_last,
    input  m1_ar_addr, m1_ar_valid, m1_r_ready,
    output m1_ar_ready, m1_r_data, m1_r_resp, m1_r_valid, m1_r_last,
    input  m1_aw_addr, m1_aw_valid, m1_w_data, m1_w_strb, m1_w_valid, m1_w_last, m1_b_ready,
    output m1_aw_ready, m1_w_ready, m1_b_resp, m1_b_valid,
    output s_ar_addr, s_ar_valid, s_ar_id, s_ar_len, s_ar_size, s_ar_burst,
    input  s_ar_ready,
    input  s_r_data, s_r_resp, s_r_valid, s_r_last, s_r_id,
    output s_r_ready,
    output s_aw_addr, s_aw_valid, s_aw_id, s_aw_len, s_aw_size, s_aw_burst,
    input  s_aw_ready,
    output s_w_data, s_w_strb, s_w_valid, s_w_last,
    input  s_w_ready,
    input  s_b_resp, s_b_valid, s_b_id,
    output s_b_ready
  );

  modport slave (
    output m0_ar_addr, m0_ar_valid, m0_r_ready,
    input  m0_ar_ready, m0_r_data, m0_r_resp, m0_r_valid, m0_r_last,
    output m1_ar_addr, m1_ar_valid, m1_r_ready,
    input  m1_ar_ready, m1_r_data, m1_r_resp, m1_r_valid, m1_r_last,
    output m1_aw_addr, m1_aw_valid, m1_w_data, m1_w_strb, m1_w_valid, m1_w_last, m1_b_ready,
    input  m1_aw_ready, m1_w_ready, m1_b_resp, m1_b_valid,
    input  s_ar_addr, s_ar_valid, s_ar_id, s_ar_len, s_ar_size, s_ar_burst,
    output s_ar_ready,
    output s_r_data, s_r_resp, s_r_valid, s_r_last, s_r_id,
    input  s_r_ready,
    input  s_aw_addr, s_aw_valid, s_aw_id, s_aw_len, s_aw_size, s_aw_burst,
    output s_aw_ready,
    input  s_w_data, s_w_strb, s_w_valid, s_w_last,
    output s_w_ready,
    output s_b_resp, s_b_valid, s_b_id,
    input  s_b_ready
  );
endinterface

// File: rtl/ysyx_23060025_addr_decode.sv
// Address to xbar device select: 1 = CLINT window, 0 = memory.
// Latency: purely combinational.
// Backpressure: none.
module ysyx_23060025_addr_decode
  import ysyx_23060025_axi_arbiter_pkg::*;
#(
  parameter int                  ADDR_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [ADDR_LEN-1:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic [ADDR_LEN-1:0] addr,
  output logic                device
);
  logic [ADDR_LEN-1:0] offset;

  // A single unsigned subtract-and-compare covers both window edges
  assign offset = addr - CLINT_BASE;
  assign device = (offset < CLINT_SIZE);
endmodule

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI arbiter; holds a grant per transaction.
// Latency: 1 IDLE cycle per grant decision, then the downstream handshakes pass straight through.
// Backpressure: only the granted master sees readies; others wait with valid held. Macro: ARB_ROUND_ROBIN_EN.
module ysyx_23060025_axi_arbiter
  import ysyx_23060025_axi_arbiter_pkg::*;
#(
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DATA_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [ADDR_LEN-1:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  ysyx_23060025_axi_arbiter_if.master    bus,
  output logic                           axi_device,
  output logic                           busy
);
  arb_state_t          state, state_next;
  logic                grant, grant_next;   // 1 = LSU
  logic [ADDR_LEN-1:0] addr_q, addr_next;
  logic [DATA_LEN-1:0] wdata_q;
  logic [3:0]          wstrb_q;
  logic                wlast_q;
  logic                aw_done, w_done;
  logic                take, take_write, pick_lsu, lsu_req;
  logic                aw_fire, w_fire, r_ready_sel, dec_device;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_grant;
`endif

  ysyx_23060025_addr_decode #(
    .ADDR_LEN  (ADDR_LEN),
    .CLINT_BASE(CLINT_BASE),
    .CLINT_SIZE(CLINT_SIZE)
  ) u_addr_decode (
    .addr  (addr_next),
    .device(dec_device)
  );

  assign lsu_req = bus.m1_ar_valid | bus.m1_aw_valid;
  assign busy    = (state != ARB_IDLE);

  // Downstream fields come from latched state so they stay fixed for the transaction
  assign bus.s_ar_addr  = addr_q;
  assign bus.s_ar_id    = grant ? ARB_ID_LSU : ARB_ID_IFU;
  assign bus.s_ar_len   = AXI_LEN_SINGLE;
  assign bus.s_ar_size  = AXI_SIZE_WORD;
  assign bus.s_ar_burst = AXI_BURST_INCR;
  assign bus.s_aw_addr  = addr_q;
  assign bus.s_aw_id    = ARB_ID_LSU;
  assign bus.s_aw_len   = AXI_LEN_SINGLE;
  assign bus.s_aw_size  = AXI_SIZE_WORD;
  assign bus.s_aw_burst = AXI_BURST_INCR;
  assign bus.s_w_data   = wdata_q;
  assign bus.s_w_strb   = wstrb_q;
  assign bus.s_w_last   = wlast_q;
  // Payloads fan out to both masters; only the valid is steered (response id is not used)
  assign bus.m0_r_data  = bus.s_r_data;
  assign bus.m0_r_resp  = bus.s_r_resp;
  assign bus.m0_r_last  = bus.s_r_last;
  assign bus.m1_r_data  = bus.s_r_data;
  assign bus.m1_r_resp  = bus.s_r_resp;
  assign bus.m1_r_last  = bus.s_r_last;
  assign bus.m1_b_resp  = bus.s_b_resp;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  // Grant, request latches and per-channel write progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      addr_q     <= '0;
      axi_device <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      if (take) begin
        grant      <= grant_next;
        addr_q     <= addr_next;
        axi_device <= dec_device;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= grant_next;
`endif
      end
      if (take_write) begin
        wdata_q <= bus.m1_w_data;
        wstrb_q <= bus.m1_w_strb;
        wlast_q <= bus.m1_w_last;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

  // Arbitration, next state and handshake steering
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    addr_next       = addr_q;
    take            = 1'b0;
    take_write      = 1'b0;
    pick_lsu        = 1'b0;
    aw_fire         = 1'b0;
    w_fire          = 1'b0;
    r_ready_sel     = 1'b0;
    bus.m0_ar_ready = 1'b0;
    bus.m1_ar_ready = 1'b0;
    bus.m1_aw_ready = 1'b0;
    bus.m1_w_ready  = 1'b0;
    bus.m0_r_valid  = 1'b0;
    bus.m1_r_valid  = 1'b0;
    bus.m1_b_valid  = 1'b0;
    bus.s_ar_valid  = 1'b0;
    bus.s_r_ready   = 1'b0;
    bus.s_aw_valid  = 1'b0;
    bus.s_w_valid   = 1'b0;
    bus.s_b_ready   = 1'b0;
    case (state)
      ARB_IDLE: begin
        pick_lsu = lsu_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (lsu_req && bus.m0_ar_valid) pick_lsu = ~last_grant;
`endif
        if (pick_lsu) begin
          take       = 1'b1;
          grant_next = 1'b1;
          if (bus.m1_aw_valid) begin
            state_next = ARB_WR_AW;
            addr_next  = bus.m1_aw_addr;
            take_write = 1'b1;
          end else begin
            state_next = ARB_RD_AR;
            addr_next  = bus.m1_ar_addr;
          end
        end else if (bus.m0_ar_valid) begin
          take       = 1'b1;
          grant_next = 1'b0;
          state_next = ARB_RD_AR;
          addr_next  = bus.m0_ar_addr;
        end
      end
      ARB_RD_AR: begin
        bus.s_ar_valid = 1'b1;
        if (grant) bus.m1_ar_ready = bus.s_ar_ready;
        else       bus.m0_ar_ready = bus.s_ar_ready;
        if (bus.s_ar_ready) state_next = ARB_RD_R;
      end
      ARB_RD_R: begin
        r_ready_sel   = grant ? bus.m1_r_ready : bus.m0_r_ready;
        bus.s_r_ready = r_ready_sel;
        if (grant) bus.m1_r_valid = bus.s_r_valid;
        else       bus.m0_r_valid = bus.s_r_valid;
        if (bus.s_r_valid && r_ready_sel && bus.s_r_last) state_next = ARB_IDLE;
      end
      ARB_WR_AW: begin
        bus.s_aw_valid  = ~aw_done;
        bus.s_w_valid   = ~w_done;
        aw_fire         = ~aw_done & bus.s_aw_ready;
        w_fire          = ~w_done & bus.s_w_ready;
        bus.m1_aw_ready = aw_fire;
        bus.m1_w_ready  = w_fire;
        if ((aw_done | aw_fire) && (w_done | w_fire)) state_next = ARB_WR_B;
      end
      ARB_WR_B: begin
        bus.s_b_ready  = bus.m1_b_ready;
        bus.m1_b_valid = bus.s_b_valid;
        if (bus.s_b_valid && bus.m1_b_ready) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Self-checking bench for the IFU/LSU AXI arbiter: directed scenarios plus randomized request mixes.
// The bench plays both masters and the downstream slave; a request-queue model predicts grant order.
// Honors ARB_ROUND_ROBIN_EN in the model so the same bench serves both builds.
module tb_ysyx_23060025_axi_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic axi_device, busy;

  ysyx_23060025_axi_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  ysyx_23060025_axi_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .axi_device(axi_device),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending requests (0 = IFU read, 1 = LSU read, 2 = LSU write)
  bit          pend [3];
  logic [31:0] pend_addr [3];
  logic [31:0] pend_wdata;
  logic [3:0]  pend_wstrb;
  bit          model_last;  // 1 = LSU granted last
  bit          model_dev;   // device select of the most recent grant

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit dev_of(input logic [31:0] a);
    // CLINT occupies [0x0200_0000, 0x0201_0000)
    return (a >= 32'h0200_0000) && (a < 32'h0201_0000);
  endfunction

  function automatic int model_pick();
    bit lsu;
    lsu = pend[1] | pend[2];
`ifdef ARB_ROUND_ROBIN_EN
    if (lsu && pend[0]) lsu = (model_last == 1'b0);
`endif
    if (lsu) return pend[2] ? 2 : 1;
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000 + ($urandom & 32'h0000_FFFC);
      1:       return 32'h0200_0000 + ($urandom & 32'h0000_FFFC);
      2:       return 32'h0200_FFFC;
      3:       return 32'h0201_0000;
      default: return 32'h01FF_FFFC;
    endcase
  endfunction

  task automatic quiet_inputs();
    bus.m0_ar_addr = '0; bus.m0_ar_valid = 1'b0; bus.m0_r_ready = 1'b0;
    bus.m1_ar_addr = '0; bus.m1_ar_valid = 1'b0; bus.m1_r_ready = 1'b0;
    bus.m1_aw_addr = '0; bus.m1_aw_valid = 1'b0;
    bus.m1_w_data = '0; bus.m1_w_strb = '0; bus.m1_w_valid = 1'b0; bus.m1_w_last = 1'b0;
    bus.m1_b_ready = 1'b0;
    bus.s_ar_ready = 1'b0;
    bus.s_r_data = '0; bus.s_r_resp = '0; bus.s_r_valid = 1'b0; bus.s_r_last = 1'b0; bus.s_r_id = '0;
    bus.s_aw_ready = 1'b0; bus.s_w_ready = 1'b0;
    bus.s_b_resp = '0; bus.s_b_valid = 1'b0; bus.s_b_id = '0;
  endtask

  task automatic raise(input int src, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    pend[src]      = 1'b1;
    pend_addr[src] = a;
    case (src)
      0: begin bus.m0_ar_addr = a; bus.m0_ar_valid = 1'b1; end
      1: begin bus.m1_ar_addr = a; bus.m1_ar_valid = 1'b1; end
      default: begin
        bus.m1_aw_addr = a; bus.m1_aw_valid = 1'b1;
        bus.m1_w_data = wd; bus.m1_w_strb = ws; bus.m1_w_valid = 1'b1; bus.m1_w_last = 1'b1;
        pend_wdata = wd; pend_wstrb = ws;
      end
    endcase
  endtask

  task automatic outputs_quiet(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk32({tag, "_valids"},
          32'({bus.s_ar_valid, bus.s_aw_valid, bus.s_w_valid, bus.m0_r_valid, bus.m1_r_valid, bus.m1_b_valid}), 32'd0);
    chk32({tag, "_readies"},
          32'({bus.m0_ar_ready, bus.m1_ar_ready, bus.m1_aw_ready, bus.m1_w_ready, bus.s_r_ready, bus.s_b_ready}), 32'd0);
  endtask

  // One IDLE cycle: nothing handshakes, select keeps the previous grant's value
  task automatic idle_check();
    @(negedge clock);
    outputs_quiet("idle");
    chk1("idle_device", axi_device, model_dev);
    @(posedge clock); #1;
  endtask

  // Serve one transaction from the bench's side. d1/d2: address/data-phase delays, -1 = random.
  task automatic serve_one(input int src, input int d1, input int d2, input bit use_rd, input logic [31:0] rd);
    logic [31:0] a, data;
    logic [1:0]  resp;
    bit          dev, gl, tgt, hs;
    int          ad, bd, rdy_d, n;
    a  = pend_addr[src];
    dev = dev_of(a);
    gl = (src != 0);
    idle_check();
    model_dev  = dev;
    model_last = gl;
    if (src != 2) begin
      ad = (d1 < 0) ? int'($urandom_range(0, 3)) : d1;
      for (int i = 0; i <= ad; i++) begin
        bus.s_ar_ready = (i == ad);
        bus.s_r_valid = 1'b1; bus.s_r_last = 1'b1; bus.m0_r_ready = 1'b1; bus.m1_r_ready = 1'b1;
        @(negedge clock);
        chk1("ar_valid", bus.s_ar_valid, 1'b1);
        chk32("ar_addr", bus.s_ar_addr, a);
        chk32("ar_id", 32'(bus.s_ar_id), gl ? 32'd1 : 32'd0);
        chk32("ar_fixed", 32'({bus.s_ar_len, bus.s_ar_size, bus.s_ar_burst}), 32'({8'd0, 3'b010, 2'b01}));
        chk1("ar_device", axi_device, dev);
        chk1("ar_busy", busy, 1'b1);
        chk1("m0_ar_ready", bus.m0_ar_ready, (src == 0) && (i == ad));
        chk1("m1_ar_ready", bus.m1_ar_ready, (src == 1) && (i == ad));
        chk32("ar_no_r", 32'({bus.m0_r_valid, bus.m1_r_valid, bus.s_r_ready, bus.m1_aw_ready, bus.s_aw_valid}), 32'd0);
        @(posedge clock); #1;
      end
      bus.s_ar_ready = 1'b0; bus.s_r_valid = 1'b0;
      if (src == 0) bus.m0_ar_valid = 1'b0; else bus.m1_ar_valid = 1'b0;
      pend[src] = 1'b0;
      bd    = (d2 < 0) ? int'($urandom_range(0, 3)) : d2;
      rdy_d = int'($urandom_range(0, 2));
      data  = use_rd ? rd : $urandom;
      resp  = 2'($urandom_range(0, 3));
      hs = 1'b0;
      for (int cyc = 0; cyc < 20 && !hs; cyc++) begin
        bus.s_r_valid = (cyc >= bd); bus.s_r_data = data; bus.s_r_resp = resp;
        bus.s_r_last = 1'b1; bus.s_r_id = 4'($urandom);
        tgt = (cyc >= rdy_d);
        if (gl) begin bus.m1_r_ready = tgt; bus.m0_r_ready = 1'($urandom); end
        else    begin bus.m0_r_ready = tgt; bus.m1_r_ready = 1'($urandom); end
        @(negedge clock);
        chk1("r_valid_granted", gl ? bus.m1_r_valid : bus.m0_r_valid, bus.s_r_valid);
        chk1("r_valid_other", gl ? bus.m0_r_valid : bus.m1_r_valid, 1'b0);
        chk1("s_r_ready", bus.s_r_ready, tgt);
        chk32("r_data", gl ? bus.m1_r_data : bus.m0_r_data, data);
        chk32("r_resp_last", 32'(gl ? {bus.m1_r_resp, bus.m1_r_last} : {bus.m0_r_resp, bus.m0_r_last}), 32'({resp, 1'b1}));
        chk1("r_device", axi_device, dev);
        chk1("r_ar_valid", bus.s_ar_valid, 1'b0);
        hs = bus.s_r_valid && bus.s_r_ready;
        @(posedge clock); #1;
      end
      chk1("r_done", hs, 1'b1);
      bus.s_r_valid = 1'b0; bus.m0_r_ready = 1'b0; bus.m1_r_ready = 1'b0;
    end else begin
      ad = (d1 < 0) ? int'($urandom_range(0, 4)) : d1;
      bd = (d2 < 0) ? int'($urandom_range(0, 4)) : d2;
      n  = (ad > bd) ? ad : bd;
      for (int i = 0; i <= n; i++) begin
        bus.s_aw_ready = (i == ad); bus.s_w_ready = (i == bd);
        bus.s_b_valid = 1'b1; bus.m1_b_ready = 1'b1;
        @(negedge clock);
        chk1("aw_valid", bus.s_aw_valid, i <= ad);
        chk1("w_valid", bus.s_w_valid, i <= bd);
        chk32("aw_addr", bus.s_aw_addr, a);
        chk32("aw_fixed", 32'({bus.s_aw_id, bus.s_aw_len, bus.s_aw_size, bus.s_aw_burst}),
              32'({4'd1, 8'd0, 3'b010, 2'b01}));
        chk32("w_data", bus.s_w_data, pend_wdata);
        chk32("w_strb_last", 32'({bus.s_w_strb, bus.s_w_last}), 32'({pend_wstrb, 1'b1}));
        chk1("m1_aw_ready", bus.m1_aw_ready, i == ad);
        chk1("m1_w_ready", bus.m1_w_ready, i == bd);
        chk32("wr_others", 32'({bus.m0_ar_ready, bus.m1_ar_ready, bus.m1_b_valid, bus.s_b_ready}), 32'd0);
        chk1("wr_device", axi_device, dev);
        chk1("wr_busy", busy, 1'b1);
        @(posedge clock); #1;
        if (i == ad) bus.m1_aw_valid = 1'b0;
        if (i == bd) bus.m1_w_valid = 1'b0;
      end
      bus.s_aw_ready = 1'b0; bus.s_w_ready = 1'b0; bus.s_b_valid = 1'b0;
      pend[2] = 1'b0;
      bd    = int'($urandom_range(0, 3));
      rdy_d = int'($urandom_range(0, 2));
      resp  = 2'($urandom_range(0, 3));
      hs = 1'b0;
      for (int cyc = 0; cyc < 20 && !hs; cyc++) begin
        bus.s_b_valid = (cyc >= bd); bus.s_b_resp = resp; bus.s_b_id = 4'($urandom);
        tgt = (cyc >= rdy_d);
        bus.m1_b_ready = tgt;
        @(negedge clock);
        chk1("b_valid", bus.m1_b_valid, bus.s_b_valid);
        chk1("s_b_ready", bus.s_b_ready, tgt);
        chk32("b_resp", 32'(bus.m1_b_resp), 32'(resp));
        chk32("b_others", 32'({bus.s_aw_valid, bus.s_w_valid, bus.m0_r_valid, bus.m1_r_valid}), 32'd0);
        chk1("b_device", axi_device, dev);
        hs = bus.s_b_valid && bus.s_b_ready;
        @(posedge clock); #1;
      end
      chk1("b_done", hs, 1'b1);
      bus.s_b_valid = 1'b0; bus.m1_b_ready = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      if (pend[0] | pend[1] | pend[2]) serve_one(model_pick(), -1, -1, 1'b0, 32'd0);
    end
  endtask

  initial begin
    quiet_inputs();
    for (int s = 0; s < 3; s++) begin pend[s] = 1'b0; pend_addr[s] = '0; end
    pend_wdata = '0; pend_wstrb = '0;
    model_last = 1'b0; model_dev = 1'b0;
    reset = 1'b1;

    // Reset state, with a request already waiting
    bus.m0_ar_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    outputs_quiet("reset");
    chk1("reset_device", axi_device, 1'b0);
    @(posedge clock); #1;
    bus.m0_ar_valid = 1'b0;
    reset = 1'b0;
    idle_check();

    // IFU reads main memory alone
    raise(0, 32'h8000_0000, '0, '0);
    serve_one(0, -1, -1, 1'b1, 32'hDEAD_BEEF);
    idle_check();

    // Simultaneous IFU and LSU reads
    raise(0, 32'h8000_0100, '0, '0);
    raise(1, 32'h8000_0200, '0, '0);
    drain();

    // LSU write, W handshake 3 cycles after AW
    raise(2, 32'h8000_0010, 32'h1234_5678, 4'b0011);
    serve_one(2, 0, 3, 1'b0, 32'd0);

    // LSU reads CLINT; select persists through the following IDLE and changes at the next grant
    raise(1, 32'h0200_BFF8, '0, '0);
    serve_one(1, -1, -1, 1'b0, 32'd0);
    idle_check();
    raise(0, 32'h8000_0004, '0, '0);
    serve_one(0, -1, -1, 1'b0, 32'd0);

    // Reset while waiting for read data
    raise(0, 32'h0200_0100, '0, '0);
    idle_check();
    bus.s_ar_ready = 1'b1;
    @(negedge clock);
    chk1("rst_pre_ar_ready", bus.m0_ar_ready, 1'b1);
    chk1("rst_pre_device", axi_device, 1'b1);
    @(posedge clock); #1;
    bus.s_ar_ready = 1'b0; bus.m0_ar_valid = 1'b0; bus.m0_r_ready = 1'b1;
    @(negedge clock);
    chk1("rst_pre_busy", busy, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    outputs_quiet("rst_mid");
    chk1("rst_mid_device", axi_device, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0; bus.m0_r_ready = 1'b0;
    pend[0] = 1'b0; model_last = 1'b0; model_dev = 1'b0;
    idle_check();

    // IFU waits through a 5-cycle LSU write, then gets the first IDLE slot
    raise(0, 32'h8000_0300, '0, '0);
    raise(2, 32'h0200_4000, 32'hCAFE_F00D, 4'b1111);
    serve_one(model_pick(), 1, 4, 1'b0, 32'd0);
    drain();

    // Randomized request mixes
    for (int it = 0; it < 30; it++) begin
      int mask;
      mask = int'($urandom_range(1, 7));
      if (mask[0]) raise(0, rand_addr(), '0, '0);
      if (mask[1]) raise(1, rand_addr(), '0, '0);
      if (mask[2]) raise(2, rand_addr(), $urandom, 4'($urandom));
      drain();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a task loop ever stalls
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
